// File: rtl/bram_rmw_pkg.sv
// Shared definitions for the BRAM read-modify-write controller.
// Holds the state encoding, the default widths and the word merge helper.
package bram_rmw_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        RMW  = 2'd2
    } state_t;

    // Bits with mask=1 come from the new data, the rest keep the stored word.
    function automatic logic [DEF_DATA_W-1:0] merge_word(
        input logic [DEF_DATA_W-1:0] old_word,
        input logic [DEF_DATA_W-1:0] wdata,
        input logic [DEF_DATA_W-1:0] mask
    );
        return (old_word & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/bram_rmw_ctrl.sv
// Port-0 request controller for the 512x32 BRAM: reads, full writes and masked writes via RMW.
// Optional RMW statistics counter is enabled with the BRAM_RMW_STATS_EN macro.
module bram_rmw_ctrl
    import bram_rmw_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    input  logic [DATA_W-1:0] REQ_WMASK,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic              CE0,
    input  logic [DATA_W-1:0] Q0
`ifdef BRAM_RMW_STATS_EN
    ,
    output logic [15:0]       STAT_RMW
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mask_q;
    logic                load_rmw;
    logic                can_accept;
    logic                accept;

    assign can_accept = (state == IDLE) || ((state == RESP) && RSP_READY);
    assign accept     = RSTN && REQ_VALID && can_accept;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state <= state_nxt;
            if (load_rmw) begin
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
                mask_q  <= REQ_WMASK;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        A0        = '0;
        D0        = '0;
        WE0       = 1'b0;
        CE0       = 1'b0;
        load_rmw  = 1'b0;
        if (!RSTN) begin
            state_nxt = IDLE;
        end else begin
            REQ_READY = can_accept;
            if (state == RESP) begin
                RSP_VALID = 1'b1;
                RSP_RDATA = Q0;
                if (RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            if (state == RMW) begin
                CE0       = 1'b1;
                WE0       = 1'b1;
                A0        = addr_q;
                D0        = merge_word(Q0, wdata_q, mask_q);
                state_nxt = IDLE;
            end
            // A new request overrides the fall-back next state chosen above.
            if (accept) begin
                if (!REQ_WE) begin
                    CE0       = 1'b1;
                    A0        = REQ_ADDR;
                    D0        = REQ_WDATA;
                    state_nxt = RESP;
                end else if (REQ_WMASK == '1) begin
                    CE0       = 1'b1;
                    WE0       = 1'b1;
                    A0        = REQ_ADDR;
                    D0        = REQ_WDATA;
                    state_nxt = IDLE;
                end else if (REQ_WMASK == '0) begin
                    state_nxt = IDLE;
                end else begin
                    CE0       = 1'b1;
                    A0        = REQ_ADDR;
                    D0        = REQ_WDATA;
                    load_rmw  = 1'b1;
                    state_nxt = RMW;
                end
            end
        end
    end

`ifdef BRAM_RMW_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            STAT_RMW <= '0;
        end else if ((state == RMW) && (STAT_RMW != 16'hFFFF)) begin
            STAT_RMW <= STAT_RMW + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Self-checking bench for bram_rmw_ctrl with a BRAM model, a reference memory and a response scoreboard.
// Also checks the STAT_RMW counter when BRAM_RMW_STATS_EN is defined.
module tb_bram_rmw_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic [DW-1:0] REQ_WMASK = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [DW-1:0] RSP_RDATA;
    logic [AW-1:0] A0;
    logic [DW-1:0] D0;
    logic          WE0;
    logic          CE0;
    logic [DW-1:0] Q0 = '0;
`ifdef BRAM_RMW_STATS_EN
    logic [15:0]   STAT_RMW;
`endif

    always #5 CLK = ~CLK;

    bram_rmw_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WMASK(REQ_WMASK),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .Q0(Q0)
`ifdef BRAM_RMW_STATS_EN
        , .STAT_RMW(STAT_RMW)
`endif
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural BRAM: whole-word write, registered read data that holds when idle.
    logic [DW-1:0] bram [0:511];
    logic          init_req = 1'b1;
    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 512; i++) bram[i] <= init_word(i);
        end else if (CE0) begin
            if (WE0) bram[A0] <= D0;
            else     Q0 <= bram[A0];
        end
    end

    logic [DW-1:0] ref_mem [0:511];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            exp_rmw = 0;
    bit            rand_rsp = 1'b0;
    logic          acc_ce;
    logic          acc_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        if (rand_rsp) RSP_READY = ($urandom_range(0, 3) != 0);
    endtask

    // Present one request, wait (bounded) for acceptance and update the reference model.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] mask);
        bit done;
        done = 1'b0;
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_WMASK = mask;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge CLK);
            if (REQ_READY) begin
                done   = 1'b1;
                acc_ce = CE0;
                acc_we = WE0;
                if (!we) begin
                    exp_q.push_back(ref_mem[addr]);
                end else begin
                    ref_mem[addr] = (ref_mem[addr] & ~mask) | (wdata & mask);
                    if (mask != '0 && mask != '1) exp_rmw++;
                end
            end
            next_cycle();
        end
        REQ_VALID = 1'b0;
        if (!done) check("accept_timeout", 64'(0), 64'(1));
    endtask

    // Scoreboard monitor: every consumed response must match the oldest expected read.
    initial begin
        forever begin
            @(negedge CLK);
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 64'(1), 64'(0));
                else                   check("rsp_data", 64'(RSP_RDATA), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [DW-1:0] old_word;
        logic [AW-1:0] a;
        int            kind;

        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

        RSTN      = 1'b0;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 9'h005;
        repeat (3) begin
            @(negedge CLK);
            check("rst_req_ready", 64'(REQ_READY), 64'(0));
            check("rst_ce0", 64'(CE0), 64'(0));
            check("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
            @(posedge CLK);
            #1;
            init_req = 1'b0;
        end
        RSTN      = 1'b1;
        REQ_VALID = 1'b0;
        next_cycle();

        issue(1'b1, 9'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
        check("full_wr_ce0", 64'(acc_ce), 64'(1));
        check("full_wr_we0", 64'(acc_we), 64'(1));
        issue(1'b0, 9'h005, '0, '0);
        @(negedge CLK);
        check("rd_latency_valid", 64'(RSP_VALID), 64'(1));
        check("rd_data_direct", 64'(RSP_RDATA), 64'(32'hDEADBEEF));
        next_cycle();

        issue(1'b1, 9'h1FF, 32'h12345678, 32'hFFFFFFFF);
        issue(1'b1, 9'h1FF, 32'hAAAAAAAA, 32'h0000FFFF);
        check("rmw_rd_ce0", 64'(acc_ce), 64'(1));
        check("rmw_rd_we0", 64'(acc_we), 64'(0));
        @(negedge CLK);
        check("rmw_req_ready", 64'(REQ_READY), 64'(0));
        check("rmw_we0", 64'(WE0), 64'(1));
        check("rmw_a0", 64'(A0), 64'(9'h1FF));
        check("rmw_d0", 64'(D0), 64'(32'h1234AAAA));
        next_cycle();
        issue(1'b0, 9'h1FF, '0, '0);
        @(negedge CLK);
        check("rmw_read_back", 64'(RSP_RDATA), 64'(32'h1234AAAA));
        next_cycle();

        issue(1'b1, 9'h010, 32'hCAFEF00D, 32'hFFFFFFFF);
        RSP_READY = 1'b0;
        issue(1'b0, 9'h010, '0, '0);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 9'h005;
        repeat (4) begin
            @(negedge CLK);
            check("stall_rsp_valid", 64'(RSP_VALID), 64'(1));
            check("stall_rsp_data", 64'(RSP_RDATA), 64'(32'hCAFEF00D));
            check("stall_req_ready", 64'(REQ_READY), 64'(0));
            check("stall_ce0", 64'(CE0), 64'(0));
            @(posedge CLK);
            #1;
        end
        RSP_READY = 1'b1;
        issue(1'b0, 9'h005, '0, '0);
        check("stream_accept_ce0", 64'(acc_ce), 64'(1));
        next_cycle();
        next_cycle();

        issue(1'b1, 9'h020, 32'h11111111, 32'hFFFFFFFF);
        old_word = ref_mem[9'h020];
        issue(1'b1, 9'h020, 32'h22222222, 32'hFF000000);
        RSTN = 1'b0;
        ref_mem[9'h020] = old_word;
        @(negedge CLK);
        check("rst_rmw_we0", 64'(WE0), 64'(0));
        check("rst_rmw_ce0", 64'(CE0), 64'(0));
        @(posedge CLK);
        #1;
        RSTN    = 1'b1;
        exp_rmw = 0;
        issue(1'b0, 9'h020, '0, '0);
        @(negedge CLK);
        check("rst_rmw_read_back", 64'(RSP_RDATA), 64'(32'h11111111));
        next_cycle();

        issue(1'b1, 9'h005, 32'h0BADF00D, 32'h00000000);
        check("zero_mask_ce0", 64'(acc_ce), 64'(0));
        issue(1'b0, 9'h005, '0, '0);
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 9'(9'h030 + k), $urandom, 32'h00000FF0 << (4 * k));
        end
        next_cycle();
`ifdef BRAM_RMW_STATS_EN
        check("stat_rmw_three", 64'(STAT_RMW), 64'(3));
`endif

        rand_rsp = 1'b1;
        repeat (300) begin
            a = 9'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = a + 9'h1F0;
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1:    issue(1'b0, a, '0, '0);
                2:       issue(1'b1, a, $urandom, 32'hFFFFFFFF);
                3:       issue(1'b1, a, $urandom, $urandom);
                default: issue(1'b1, a, $urandom, 32'h00000000);
            endcase
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
        rand_rsp  = 1'b0;
        RSP_READY = 1'b1;
        repeat (4) next_cycle();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
`ifdef BRAM_RMW_STATS_EN
        check("stat_rmw_final", 64'(STAT_RMW), 64'((exp_rmw > 65535) ? 65535 : exp_rmw));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
